// File: rtl/ld_proj_to_affine.sv
// ld_proj_to_affine: converts a Lopez-Dahab projective point (X,Y,Z) over
// GF(2^M) to affine coordinates x = X/Z, y = Y/Z^2. Z^-1 is obtained by
// Fermat inversion Z^(2^M-2), computed sequentially with one square and one
// multiply per cycle. One conversion is in flight at a time.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready decoded from state)
//   X_in, Y_in, Z_in      projective coordinates, M bits each
//   out_valid / out_ready output handshake
//   out_x, out_y          affine coordinates, M bits each
//   out_inf               input was the point at infinity (Z==0)
module ld_proj_to_affine #(
    parameter int unsigned M    = 3,
    parameter logic [M-1:0] POLY = M'(3'b011)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] X_in,
    input  logic [M-1:0] Y_in,
    input  logic [M-1:0] Z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_x,
    output logic [M-1:0] out_y,
    output logic         out_inf
);

    localparam int unsigned CW = $clog2(M) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INV  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Shift-and-add GF(2^M) multiply, reducing by x^M + POLY after each shift.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic         msb;
        r = '0;
        for (int i = int'(M) - 1; i >= 0; i--) begin
            msb = r[M-1];
            r   = {r[M-2:0], 1'b0};
            if (msb)  r = r ^ POLY;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    logic [1:0]    state, state_d;
    logic [M-1:0]  x_q, x_d;
    logic [M-1:0]  y_q, y_d;
    logic          zero_q, zero_d;
    logic [M-1:0]  t_q, t_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  out_x_d, out_y_d;
    logic          out_inf_d, out_valid_d;
    logic [M-1:0]  t_sq, inv2;

    assign in_ready = (state == S_IDLE);
    assign t_sq     = gf_mul(t_q, t_q);
    assign inv2     = gf_mul(acc_q, acc_q);

    // Next-state and datapath update.
    always_comb begin
        state_d     = state;
        x_d         = x_q;
        y_d         = y_q;
        zero_d      = zero_q;
        t_d         = t_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_x_d     = out_x;
        out_y_d     = out_y;
        out_inf_d   = out_inf;
        out_valid_d = out_valid;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = X_in;
                    y_d     = Y_in;
                    zero_d  = (Z_in == '0);
                    t_d     = Z_in;
                    acc_d   = M'(1);
                    cnt_d   = CW'(1);
                    state_d = S_INV;
                end
            end
            S_INV: begin
                // acc accumulates Z^(2+4+..+2^cnt); after M-1 steps it is Z^-1.
                t_d   = t_sq;
                acc_d = gf_mul(acc_q, t_sq);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(M - 1)) state_d = S_CONV;
            end
            S_CONV: begin
                // Z==0 yields acc==0, so both coordinates fall out as zero.
                out_x_d     = gf_mul(x_q, acc_q);
                out_y_d     = gf_mul(y_q, inv2);
                out_inf_d   = zero_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            zero_q    <= 1'b0;
            t_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_inf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            zero_q    <= zero_d;
            t_q       <= t_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_x     <= out_x_d;
            out_y     <= out_y_d;
            out_inf   <= out_inf_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ld_proj_to_affine.sv
// Bench for ld_proj_to_affine (M=3, POLY=x^3+x+1): a transaction-level model
// predicts handshake and output values every cycle; directed points pin the
// field arithmetic with literal expectations; random points run back-to-back.
module tb_ld_proj_to_affine;

    localparam int unsigned M = 3;
    localparam logic [2:0]  POLY = 3'b011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] X_in = '0, Y_in = '0, Z_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_x, out_y;
    logic       out_inf;

    ld_proj_to_affine #(.M(M), .POLY(POLY)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .X_in(X_in), .Y_in(Y_in), .Z_in(Z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_inf(out_inf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Full carry-less product, then long division by x^3 + POLY.
    function automatic logic [2:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        logic [3:0] full_poly;
        p = '0;
        full_poly = {1'b1, POLY};
        for (int i = 0; i < 3; i++)
            if (b[i]) p = p ^ (5'(a) << i);
        for (int k = 4; k >= 3; k--)
            if (p[k]) p = p ^ (5'(full_poly) << (k - 3));
        return p[2:0];
    endfunction

    // Inverse by exhaustive search; zero maps to zero.
    function automatic logic [2:0] ref_inv(input logic [2:0] z);
        logic [2:0] w;
        for (int i = 1; i < 8; i++) begin
            w = 3'(i);
            if (ref_mul(z, w) == 3'd1) return w;
        end
        return 3'd0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: idle / busy countdown / result-held.
    int         busy = 0;
    bit         mv = 1'b0;
    logic [2:0] mx = '0, my = '0;
    bit         minf = 1'b0;
    int         acc_cnt = 0;
    int         cyc = 0;
    int         acc_cyc[$];
    bit         chk_on = 1'b0;

    always @(posedge clk) begin
        logic [2:0] inv;
        cyc++;
        if (!rst_n) begin
            busy = 0; mv = 1'b0; mx = '0; my = '0; minf = 1'b0;
        end else if (mv) begin
            if (out_ready) mv = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) mv = 1'b1;
        end else if (in_valid) begin
            inv  = ref_inv(Z_in);
            busy = int'(M);
            // Result becomes visible M edges later; stash it now.
            mx   = ref_mul(X_in, inv);
            my   = ref_mul(Y_in, ref_mul(inv, inv));
            minf = (Z_in == 3'd0);
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
    end

    // Shadow outputs: model values only show once mv rises, held afterwards.
    logic [2:0] sx = '0, sy = '0;
    bit         sinf = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            sx = '0; sy = '0; sinf = 1'b0;
        end else if (mv) begin
            sx = mx; sy = my; sinf = minf;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready", 32'(in_ready), 32'(!mv && busy == 0));
            check("out_valid", 32'(out_valid), 32'(mv));
            check("out_x", 32'(out_x), 32'(sx));
            check("out_y", 32'(out_y), 32'(sy));
            check("out_inf", 32'(out_inf), 32'(sinf));
        end
    end

    task automatic present(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
        int n0;
        bit got;
        X_in = x; Y_in = y; Z_in = z;
        in_valid = 1'b1;
        n0 = acc_cnt;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #2;
            if (acc_cnt != n0) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout: got none expected accept at %0t", $time);
        end
    endtask

    task automatic wait_valid();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL valid_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic run_point(input string nm, input logic [2:0] x, input logic [2:0] y,
                             input logic [2:0] z, input logic [2:0] ex, input logic [2:0] ey,
                             input logic einf);
        present(x, y, z);
        in_valid = 1'b0;
        wait_valid();
        check({nm, "_x"}, 32'(out_x), 32'(ex));
        check({nm, "_y"}, 32'(out_y), 32'(ey));
        check({nm, "_inf"}, 32'(out_inf), 32'(einf));
        @(posedge clk); #2;
    endtask

    initial begin
        int base;
        logic [2:0] rx, ry, rz;

        rst_n = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;

        // Latency: accept to out_valid is exactly M edges.
        present(3'd5, 3'd3, 3'd1);
        base = acc_cyc[acc_cyc.size() - 1];
        in_valid = 1'b0;
        wait_valid();
        check("latency", 32'(cyc - base), 32'(M));
        check("z1_x", 32'(out_x), 32'd5);
        check("z1_y", 32'(out_y), 32'd3);
        check("z1_inf", 32'(out_inf), 32'd0);
        @(posedge clk); #2;

        run_point("z2", 3'd2, 3'd2, 3'd2, 3'd1, 3'd5, 1'b0);
        run_point("zinf", 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 1'b1);
        run_point("z3", 3'd3, 3'd3, 3'd3, 3'd1, 3'd6, 1'b0);

        // Reset mid-inversion, with nonzero outputs still held from before.
        present(3'd7, 3'd7, 3'd6);
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_x", 32'(out_x), 32'd0);
        check("midrst_out_y", 32'(out_y), 32'd0);
        @(posedge clk); #2;

        // Stall in DONE with a competing input offered.
        out_ready = 1'b0;
        present(3'd6, 3'd1, 3'd2);
        in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #2;
        X_in = 3'd1; Y_in = 3'd1; Z_in = 3'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_x", 32'(out_x), 32'(ref_mul(3'd6, 3'd5)));
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;

        // Back-to-back random finite points with out_ready held high.
        base = acc_cyc.size();
        for (int i = 0; i < 8; i++) begin
            rx = 3'($urandom_range(0, 7));
            ry = 3'($urandom_range(0, 7));
            rz = 3'($urandom_range(1, 7));
            present(rx, ry, rz);
        end
        in_valid = 1'b0;
        for (int i = base + 1; i < acc_cyc.size(); i++)
            check("accept_spacing", 32'(acc_cyc[i] - acc_cyc[i - 1]), 32'(M + 2));
        for (int i = 0; i < 12; i++) @(posedge clk);
        @(negedge clk);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
